ps2_arrow_parser: RTL and testbench
===================================

PS2_ARROW_PARSER -- requirements
Module: ps2_arrow_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, cycles without a byte before a pending prefix is abandoned (20 ms at 50 MHz).
REQ-002 SHALL have port clock, input, 1, single system clock; all logic on posedge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port received_data, input, 8, PS/2 byte from PS2_Controller.
REQ-005 SHALL have port received_data_en, input, 1, one-cycle strobe qualifying received_data.
REQ-006 SHALL have ports key_up, key_down, key_left, key_right, output, 1 each, level: arrow currently held.
REQ-007 SHALL have port press_valid, output, 1, one-cycle pulse on accepted make event.
REQ-008 SHALL have port release_valid, output, 1, one-cycle pulse on break event.
REQ-009 SHALL have port event_dir, output, 2, direction of current pulse: 0 up, 1 down, 2 left, 3 right; held until next event.
REQ-010 SHALL have port sync_error, output, 1, one-cycle pulse on timeout or line error.

Function
REQ-011 SHALL recognise arrow codes 0x75 up, 0x72 down, 0x6B left, 0x74 right, with or without preceding 0xE0.
REQ-012 SHALL implement FSM states IDLE, EXT, BRK, EXT_BRK; bytes processed only when received_data_en=1.
REQ-013 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; arrow -> make event, stay IDLE; other byte ignored.
REQ-014 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; arrow -> make event, IDLE; other -> IDLE, no event.
REQ-015 BRK/EXT_BRK: arrow -> release event; any byte -> IDLE.
REQ-016 Make event: set held bit, event_dir updated, press_valid=1 on the cycle after the strobe (latency 1).
REQ-017 Release event: clear held bit, event_dir updated, release_valid=1 on the cycle after the strobe; release of a non-held key still pulses.
REQ-018 press_valid and release_valid SHALL never be high together; sync_error never coincides with either.
REQ-019 Bytes 0x00 or 0xFF (keyboard overrun) in any state: clear all held bits, -> IDLE, sync_error pulse next cycle.
REQ-020 Timeout counter SHALL clear on every strobe and in IDLE, increment otherwise; on reaching TIMEOUT_CYCLES-1: -> IDLE, sync_error pulse, held bits kept, counter cleared.
REQ-021 Strobe in the same cycle the counter hits terminal count: byte processed, no timeout, counter cleared.
REQ-022 Counter width SHALL be $clog2(TIMEOUT_CYCLES); counter SHALL not wrap.
REQ-023 Multiple arrows SHALL be holdable simultaneously; each held bit independent.

Reset
REQ-024 With reset=1 at a clock edge: state IDLE, counter 0, all key_* 0, press_valid 0, release_valid 0, event_dir 0, sync_error 0.
REQ-025 Reset mid-sequence (e.g. after 0xE0 0xF0) SHALL discard the prefix; next arrow byte after reset is a make.
REQ-026 Strobes coincident with reset SHALL be ignored.

Configuration
REQ-027 Macro PS2_TYPEMATIC_FILTER_EN: when defined, a make for an already-held key updates nothing and produces no press_valid; when undefined, every make (including autorepeat) pulses press_valid.

Verification
REQ-028 Bytes E0,75 -> key_up=1, press_valid 1 cycle after 0x75 strobe, event_dir=0.
REQ-029 Bytes E0,75 then E0,F0,75 -> release_valid pulse, event_dir=0, key_up=0.
REQ-030 Bytes 6B,6B,6B -> key_left=1; 3 press_valid pulses without PS2_TYPEMATIC_FILTER_EN, 1 with it.
REQ-031 Byte E0 then idle TIMEOUT_CYCLES (set to 16) -> sync_error pulse once, state IDLE; subsequent 72 -> key_down make.
REQ-032 Hold up and right, then byte 0x00 -> all key_* 0, sync_error pulse, no release_valid.
REQ-033 Bytes E0,F0 then reset for 1 cycle then 74 -> key_right=1, press_valid, no release_valid.

Source files
------------

// File: rtl/ps2_arrow_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_arrow_parser                                              |
// | Function : Decodes the PS/2 byte stream into held-state levels and       |
// |            make/break pulses for the four arrow keys. Handles the 0xE0   |
// |            extended prefix, 0xF0 break prefix, keyboard overrun bytes    |
// |            (0x00 / 0xFF) and abandons stale prefixes after a timeout.    |
// | Options  : PS2_TYPEMATIC_FILTER_EN - when defined, a make for a key that |
// |            is already held is swallowed (no autorepeat press pulses).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_arrow_parser #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       press_valid,
    output logic       release_valid,
    output logic [1:0] event_dir,
    output logic       sync_error
);

    // Counter is wide enough to hold TIMEOUT_CYCLES-1; a degenerate
    // TIMEOUT_CYCLES of 1 still gets a one-bit counter.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_BYTE_EXT     = 8'hE0;
    localparam logic [7:0] c_BYTE_BRK     = 8'hF0;
    localparam logic [7:0] c_BYTE_OVR_LO  = 8'h00;
    localparam logic [7:0] c_BYTE_OVR_HI  = 8'hFF;
    localparam logic [7:0] c_CODE_UP      = 8'h75;
    localparam logic [7:0] c_CODE_DOWN    = 8'h72;
    localparam logic [7:0] c_CODE_LEFT    = 8'h6B;
    localparam logic [7:0] c_CODE_RIGHT   = 8'h74;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_held;
    logic                 r_press;
    logic                 r_release;
    logic [1:0]           r_event_dir;
    logic                 r_sync_err;

    logic                 w_is_arrow;
    logic [1:0]           w_arrow_dir;
    logic                 w_overrun;
    logic                 w_make_ok;
    logic                 w_in_make_state;
    logic                 w_in_brk_state;
    logic                 w_do_make;
    logic                 w_do_release;
    logic                 w_timeout;

    // Classify the incoming byte as one of the four arrow codes.
    always_comb begin
        w_is_arrow  = 1'b1;
        w_arrow_dir = c_DIR_UP;
        case (received_data)
            c_CODE_UP:    w_arrow_dir = c_DIR_UP;
            c_CODE_DOWN:  w_arrow_dir = c_DIR_DOWN;
            c_CODE_LEFT:  w_arrow_dir = c_DIR_LEFT;
            c_CODE_RIGHT: w_arrow_dir = c_DIR_RIGHT;
            default:      w_is_arrow  = 1'b0;
        endcase
    end

    assign w_overrun = (received_data == c_BYTE_OVR_LO) ||
                       (received_data == c_BYTE_OVR_HI);

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Autorepeat of a key already down is not a new press.
    assign w_make_ok = ~r_held[w_arrow_dir];
`else
    assign w_make_ok = 1'b1;
`endif

    assign w_in_make_state = (r_state == ST_IDLE) || (r_state == ST_EXT);
    assign w_in_brk_state  = (r_state == ST_BRK)  || (r_state == ST_EXT_BRK);

    // Overrun bytes outrank everything, including an arrow-looking byte in
    // a break state (0x00/0xFF are never arrow codes anyway).
    assign w_do_make    = received_data_en && !w_overrun && w_is_arrow &&
                          w_in_make_state && w_make_ok;
    assign w_do_release = received_data_en && !w_overrun && w_is_arrow &&
                          w_in_brk_state;

    // A strobe on the terminal-count cycle wins: the byte is processed.
    assign w_timeout = !received_data_en && (r_state != ST_IDLE) &&
                       (r_cnt == c_TERMINAL);

    // Prefix-abandon counter: runs only while a prefix is pending, saturates
    // at the terminal count by clearing there, so it never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (received_data_en || (r_state == ST_IDLE) || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Prefix-tracking FSM with registered event pulses and held-key levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_held      <= 4'b0000;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_event_dir <= c_DIR_UP;
            r_sync_err  <= 1'b0;
        end else begin
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_sync_err <= 1'b0;

            if (w_do_make) begin
                r_held[w_arrow_dir] <= 1'b1;
                r_event_dir         <= w_arrow_dir;
                r_press             <= 1'b1;
            end

            if (w_do_release) begin
                r_held[w_arrow_dir] <= 1'b0;
                r_event_dir         <= w_arrow_dir;
                r_release           <= 1'b1;
            end

            if (received_data_en) begin
                if (w_overrun) begin
                    // Keyboard lost bytes: nothing we believe is held can be
                    // trusted any more.
                    r_held     <= 4'b0000;
                    r_state    <= ST_IDLE;
                    r_sync_err <= 1'b1;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (received_data == c_BYTE_EXT) begin
                                r_state <= ST_EXT;
                            end else if (received_data == c_BYTE_BRK) begin
                                r_state <= ST_BRK;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_EXT: begin
                            if (received_data == c_BYTE_BRK) begin
                                r_state <= ST_EXT_BRK;
                            end else if (received_data == c_BYTE_EXT) begin
                                r_state <= ST_EXT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_BRK, ST_EXT_BRK: begin
                            r_state <= ST_IDLE;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end else if (w_timeout) begin
                // Stale prefix: drop it but keep the held keys as they are.
                r_state    <= ST_IDLE;
                r_sync_err <= 1'b1;
            end
        end
    end

    assign key_up        = r_held[c_DIR_UP];
    assign key_down      = r_held[c_DIR_DOWN];
    assign key_left      = r_held[c_DIR_LEFT];
    assign key_right     = r_held[c_DIR_RIGHT];
    assign press_valid   = r_press;
    assign release_valid = r_release;
    assign event_dir     = r_event_dir;
    assign sync_error    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ps2_arrow_parser                                           |
// | Function : Self-checking bench for ps2_arrow_parser: directed scenarios  |
// |            with literal expectations plus randomized byte streams        |
// |            compared every cycle against a behavioural model.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ps2_arrow_parser;

    localparam int c_TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       key_up, key_down, key_left, key_right;
    logic       press_valid, release_valid, sync_error;
    logic [1:0] event_dir;

    int checks = 0;
    int errors = 0;

    ps2_arrow_parser #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .key_up           (key_up),
        .key_down         (key_down),
        .key_left         (key_left),
        .key_right        (key_right),
        .press_valid      (press_valid),
        .release_valid    (release_valid),
        .event_dir        (event_dir),
        .sync_error       (sync_error)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // Tracks "which prefixes are pending" and "how long since the last byte"
    // rather than any state encoding.
    logic [3:0] m_held    = 4'b0;
    logic       m_press   = 1'b0;
    logic       m_release = 1'b0;
    logic       m_err     = 1'b0;
    logic [1:0] m_dir     = 2'd0;
    bit         m_ext_pending = 1'b0;
    bit         m_brk_pending = 1'b0;
    int         m_quiet   = 0;
    bit         m_live    = 1'b0;

    function automatic bit arrow_of(input logic [7:0] b, output logic [1:0] d);
        d = 2'd0;
        if (b == 8'h75) begin d = 2'd0; return 1'b1; end
        if (b == 8'h72) begin d = 2'd1; return 1'b1; end
        if (b == 8'h6B) begin d = 2'd2; return 1'b1; end
        if (b == 8'h74) begin d = 2'd3; return 1'b1; end
        return 1'b0;
    endfunction

    always @(posedge clock) begin
        logic [1:0] d;
        bit         arrow;
        bit         filtered;
        m_live    = 1'b1;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_err     = 1'b0;
        if (reset) begin
            m_held = 4'b0; m_dir = 2'd0;
            m_ext_pending = 1'b0; m_brk_pending = 1'b0; m_quiet = 0;
        end else if (received_data_en) begin
            m_quiet = 0;
            arrow = arrow_of(received_data, d);
            if (received_data == 8'h00 || received_data == 8'hFF) begin
                m_held = 4'b0; m_err = 1'b1;
                m_ext_pending = 1'b0; m_brk_pending = 1'b0;
            end else if (m_brk_pending) begin
                if (arrow) begin m_held[d] = 1'b0; m_dir = d; m_release = 1'b1; end
                m_ext_pending = 1'b0; m_brk_pending = 1'b0;
            end else if (received_data == 8'hE0) begin
                m_ext_pending = 1'b1;
            end else if (received_data == 8'hF0) begin
                m_ext_pending = 1'b0; m_brk_pending = 1'b1;
            end else begin
                if (arrow) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    filtered = m_held[d];
`else
                    filtered = 1'b0;
`endif
                    if (!filtered) begin m_held[d] = 1'b1; m_dir = d; m_press = 1'b1; end
                end
                m_ext_pending = 1'b0;
            end
        end else if (m_ext_pending || m_brk_pending) begin
            m_quiet++;
            if (m_quiet == c_TIMEOUT) begin
                m_ext_pending = 1'b0; m_brk_pending = 1'b0; m_err = 1'b1; m_quiet = 0;
            end
        end
    end

    // Every cycle, DUT outputs must match the model.
    always @(negedge clock) begin
        if (m_live) begin
            checks++;
            if ({key_right, key_left, key_down, key_up, press_valid, release_valid, event_dir, sync_error}
                !== {m_held, m_press, m_release, m_dir, m_err}) begin
                errors++;
                $display("FAIL model_cmp t=%0t: dut held=%b p=%b r=%b dir=%0d err=%b, model held=%b p=%b r=%b dir=%0d err=%b",
                         $time, {key_right, key_left, key_down, key_up}, press_valid, release_valid,
                         event_dir, sync_error, m_held, m_press, m_release, m_dir, m_err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change only #1 after a rising edge; returns #1 after the edge
    // that sampled the strobe, i.e. inside the output pulse cycle.
    task automatic send(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(posedge clock); #1;
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic pulse_reset(input bit with_strobe, input logic [7:0] b);
        reset            = 1'b1;
        received_data    = b;
        received_data_en = with_strobe;
        @(posedge clock); #1;
        reset            = 1'b0;
        received_data_en = 1'b0;
    endtask

    logic [7:0] arrows [4];

    initial begin
        int presses;
        int errs;
        int first_err;
        arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h6B; arrows[3] = 8'h74;
        reset = 1'b1; received_data = 8'h00; received_data_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs",
            {28'd0, key_up, key_down, key_left, key_right}, 32'd0);
        chk("reset_pulses", {29'd0, press_valid, release_valid, sync_error}, 32'd0);
        chk("reset_dir", {30'd0, event_dir}, 32'd0);
        reset = 1'b0;
        idle(2);

        // E0,75 -> up make
        send(8'hE0);
        send(8'h75);
        chk("make_up_press", press_valid, 1);
        chk("make_up_key", key_up, 1);
        chk("make_up_dir", event_dir, 0);
        chk("make_up_norel", release_valid, 0);
        chk("model_pin_up", m_held[0], 1);
        idle(1);
        chk("make_up_pulse_width", press_valid, 0);

        // E0,F0,75 -> up release
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("brk_up_release", release_valid, 1);
        chk("brk_up_key", key_up, 0);
        chk("brk_up_dir", event_dir, 0);
        chk("brk_up_nopress", press_valid, 0);
        chk("model_pin_rel", m_release, 1);

        // 6B x3 -> typematic
        presses = 0;
        repeat (3) begin send(8'h6B); presses += press_valid; end
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typematic_presses", presses, 1);
`else
        chk("typematic_presses", presses, 3);
`endif
        chk("typematic_left", key_left, 1);
        chk("typematic_dir", event_dir, 2);

        // E0 then silence -> one timeout pulse after 16 quiet cycles
        send(8'hE0);
        errs = 0; first_err = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (sync_error) begin errs++; if (first_err == 0) first_err = i; end
        end
        chk("timeout_count", errs, 1);
        chk("timeout_cycle", first_err, c_TIMEOUT);
        chk("timeout_keeps_held", key_left, 1);
        send(8'h72);
        chk("post_timeout_press", press_valid, 1);
        chk("post_timeout_down", key_down, 1);
        chk("post_timeout_dir", event_dir, 1);

        // Strobe on the terminal-count cycle: processed, no timeout
        send(8'hE0);
        idle(c_TIMEOUT - 1);
        send(8'h75);
        chk("terminal_strobe_press", press_valid, 1);
        chk("terminal_strobe_noerr", sync_error, 0);

        // Hold right too, then overrun 0x00
        send(8'hE0); send(8'h74);
        chk("right_make", key_right, 1);
        send(8'h00);
        chk("overrun_err", sync_error, 1);
        chk("overrun_norel", release_valid, 0);
        chk("overrun_keys", {28'd0, key_up, key_down, key_left, key_right}, 0);

        // Overrun 0xFF inside a break prefix
        send(8'h75);
        send(8'hF0); send(8'hFF);
        chk("overrun_brk_err", sync_error, 1);
        chk("overrun_brk_norel", release_valid, 0);
        chk("overrun_brk_up", key_up, 0);

        // E0,F0, reset (with coincident strobe), then 74 is a make
        send(8'hE0); send(8'hF0);
        pulse_reset(1'b1, 8'h74);
        chk("midseq_reset_keys", {28'd0, key_up, key_down, key_left, key_right}, 0);
        chk("midseq_reset_pulses", {29'd0, press_valid, release_valid, sync_error}, 0);
        send(8'h74);
        chk("after_reset_right", key_right, 1);
        chk("after_reset_press", press_valid, 1);
        chk("after_reset_norel", release_valid, 0);

        // Randomized traffic, checked against the model every cycle
        for (int i = 0; i < 2500; i++) begin
            int op;
            int r;
            logic [7:0] b;
            op = $urandom_range(0, 99);
            if (op < 1) begin
                pulse_reset($urandom_range(0, 1) == 1, arrows[$urandom_range(0, 3)]);
            end else if (op < 6) begin
                idle($urandom_range(10, 20));
            end else if (op < 50) begin
                r = $urandom_range(0, 15);
                if (r <= 7)       b = arrows[$urandom_range(0, 3)];
                else if (r <= 9)  b = 8'hE0;
                else if (r <= 11) b = 8'hF0;
                else if (r == 12) b = ($urandom_range(0, 3) == 0) ?
                                      (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00) :
                                      arrows[$urandom_range(0, 3)];
                else              b = 8'($urandom_range(1, 254));
                send(b);
            end else begin
                idle(1);
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
